dmem_arbiter: RTL and testbench

- Shares the single-port data memory (`dmem`/ROM plus switch-mapped I/O words) between two requesters.
  - CPU load/store port.
  - Read-only video/display scanner port.
- Grants at most one access per cycle, drives the memory port, and routes the 1-cycle-latency read data back to the owner.
- Sits between the datapath/video logic and `dmem`.

---
 rtl/dmem_arbiter.sv | 137 +++++++++++++
 tb/tb_dmem_arbiter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between the CPU load/store port and the video scanner.
// Optional macro DMEM_ARB_RR_EN selects round-robin arbitration; default is CPU priority with video starvation override.
module dmem_arbiter #(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdata,
  input  logic          vid_req,
  input  logic [AW-1:0] vid_addr,
  output logic          vid_gnt,
  output logic          vid_rvalid,
  output logic [DW-1:0] vid_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [2:0]    wait_cnt
);

  typedef enum logic [1:0] {RESP_NONE, RESP_CPU, RESP_VID} resp_t;

  resp_t         resp_owner;
  logic          cpu_win;
  logic          vid_win;
  logic [DW-1:0] cpu_rdata_q;
  logic [DW-1:0] vid_rdata_q;

`ifdef DMEM_ARB_RR_EN
  typedef enum logic {OWN_CPU, OWN_VID} owner_t;
  owner_t last_owner;
`else
  localparam logic [2:0] WAIT_LIMIT = 3'(MAX_WAIT);
`endif

  // Contention resolution; a lone requester always wins.
  always_comb begin
    cpu_win = 1'b0;
    vid_win = 1'b0;
    if (cpu_req && vid_req) begin
`ifdef DMEM_ARB_RR_EN
      if (last_owner == OWN_CPU) vid_win = 1'b1;
      else                       cpu_win = 1'b1;
`else
      if (wait_cnt == WAIT_LIMIT) vid_win = 1'b1;
      else                        cpu_win = 1'b1;
`endif
    end else begin
      cpu_win = cpu_req;
      vid_win = vid_req;
    end
  end

  // Grants are forced low while reset is asserted so dmem sees no access.
  assign cpu_gnt = rst_n & cpu_win;
  assign vid_gnt = rst_n & vid_win;

  always_comb begin
    mem_en    = cpu_gnt | vid_gnt;
    mem_we    = cpu_gnt & cpu_we;
    mem_addr  = '0;
    mem_wdata = '0;
    if (cpu_gnt) begin
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (vid_gnt) begin
      mem_addr  = vid_addr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else begin
`ifdef DMEM_ARB_RR_EN
      wait_cnt <= '0;
`else
      if (vid_req && !vid_gnt) begin
        if (wait_cnt != WAIT_LIMIT) wait_cnt <= wait_cnt + 3'd1;
      end else begin
        wait_cnt <= '0;
      end
`endif
    end
  end

`ifdef DMEM_ARB_RR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_owner <= OWN_CPU;
    end else if (cpu_gnt) begin
      last_owner <= OWN_CPU;
    end else if (vid_gnt) begin
      last_owner <= OWN_VID;
    end
  end
`endif

  // Remember who owns the read returning next cycle; writes return nothing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_owner <= RESP_NONE;
    end else if (cpu_gnt && !cpu_we) begin
      resp_owner <= RESP_CPU;
    end else if (vid_gnt) begin
      resp_owner <= RESP_VID;
    end else begin
      resp_owner <= RESP_NONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_rdata_q <= '0;
      vid_rdata_q <= '0;
    end else begin
      if (resp_owner == RESP_CPU) cpu_rdata_q <= mem_rdata;
      if (resp_owner == RESP_VID) vid_rdata_q <= mem_rdata;
    end
  end

  // The owner sees memory data directly; the other port keeps its last word.
  assign cpu_rvalid = (resp_owner == RESP_CPU);
  assign vid_rvalid = (resp_owner == RESP_VID);
  assign cpu_rdata  = cpu_rvalid ? mem_rdata : cpu_rdata_q;
  assign vid_rdata  = vid_rvalid ? mem_rdata : vid_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed plus random stimulus against a transaction-level reference of the arbiter.
// Build with DMEM_ARB_RR_EN defined to exercise the round-robin variant.
module tb_dmem_arbiter;
  localparam int AW       = 32;
  localparam int DW       = 32;
  localparam int MAX_WAIT = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cpu_req = 1'b0;
  logic          cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic          cpu_gnt;
  logic          cpu_rvalid;
  logic [DW-1:0] cpu_rdata;
  logic          vid_req = 1'b0;
  logic [AW-1:0] vid_addr = '0;
  logic          vid_gnt;
  logic          vid_rvalid;
  logic [DW-1:0] vid_rdata;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic [2:0]    wait_cnt;

  dmem_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_gnt(vid_gnt),
    .vid_rvalid(vid_rvalid), .vid_rdata(vid_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .wait_cnt(wait_cnt)
  );

  always #5 clk = ~clk;

  // Stand-in for dmem: 256 words, word 254 holds the switch snapshot.
  logic [DW-1:0] dmem_words [256];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) dmem_words[mem_addr[7:0]] <= mem_wdata;
      else        mem_rdata <= dmem_words[mem_addr[7:0]];
    end
  end

  // Reference model: memory image, starvation count, last owner, pending response.
  logic [DW-1:0] ref_mem [256];
  int            ref_wait;
  int            ref_last;
  int            ref_resp;
  logic [DW-1:0] ref_resp_data;
  logic [DW-1:0] ref_cpu_hold;
  logic [DW-1:0] ref_vid_hold;
  bit            cpu_hold_known;
  bit            vid_hold_known;
  bit            exp_cpu_gnt;
  bit            exp_vid_gnt;
  int            n_vec = 0;
  int            n_miss = 0;

  task automatic check_val(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic ref_reset();
    ref_wait       = 0;
    ref_last       = 0;
    ref_resp       = 0;
    cpu_hold_known = 1'b0;
    vid_hold_known = 1'b0;
  endtask

  task automatic ref_grant();
    exp_cpu_gnt = 1'b0;
    exp_vid_gnt = 1'b0;
    if (!rst_n) return;
    if (cpu_req && vid_req) begin
`ifdef DMEM_ARB_RR_EN
      if (ref_last == 0) exp_vid_gnt = 1'b1;
      else               exp_cpu_gnt = 1'b1;
`else
      if (ref_wait >= MAX_WAIT) exp_vid_gnt = 1'b1;
      else                      exp_cpu_gnt = 1'b1;
`endif
    end else begin
      exp_cpu_gnt = cpu_req;
      exp_vid_gnt = vid_req;
    end
  endtask

  task automatic applyStimulus(input bit creq, input bit cwe, input logic [AW-1:0] caddr,
                               input logic [DW-1:0] cwdata, input bit vreq, input logic [AW-1:0] vaddr);
    cpu_req   = creq;
    cpu_we    = cwe;
    cpu_addr  = caddr;
    cpu_wdata = cwdata;
    vid_req   = vreq;
    vid_addr  = vaddr;
  endtask

  task automatic checkOutput();
    logic [AW-1:0] exp_addr;
    ref_grant();
    exp_addr = exp_cpu_gnt ? cpu_addr : (exp_vid_gnt ? vid_addr : '0);
    check_val("cpu_gnt", 32'(cpu_gnt), 32'(exp_cpu_gnt));
    check_val("vid_gnt", 32'(vid_gnt), 32'(exp_vid_gnt));
    check_val("mem_en", 32'(mem_en), 32'(exp_cpu_gnt | exp_vid_gnt));
    check_val("mem_we", 32'(mem_we), 32'(exp_cpu_gnt & cpu_we));
    check_val("mem_addr", mem_addr, exp_addr);
    if (exp_cpu_gnt) check_val("mem_wdata", mem_wdata, cpu_wdata);
    check_val("wait_cnt", 32'(wait_cnt), 32'(ref_wait));
    check_val("cpu_rvalid", 32'(cpu_rvalid), 32'(ref_resp == 1));
    check_val("vid_rvalid", 32'(vid_rvalid), 32'(ref_resp == 2));
    if (ref_resp == 1)      check_val("cpu_rdata", cpu_rdata, ref_resp_data);
    else if (cpu_hold_known) check_val("cpu_rdata_hold", cpu_rdata, ref_cpu_hold);
    if (ref_resp == 2)      check_val("vid_rdata", vid_rdata, ref_resp_data);
    else if (vid_hold_known) check_val("vid_rdata_hold", vid_rdata, ref_vid_hold);
  endtask

  // Advance the reference by one clock using the grants decided this cycle.
  task automatic finish_cycle();
    @(posedge clk);
    #1;
    if (ref_resp == 1) begin ref_cpu_hold = ref_resp_data; cpu_hold_known = 1'b1; end
    if (ref_resp == 2) begin ref_vid_hold = ref_resp_data; vid_hold_known = 1'b1; end
    ref_resp = 0;
    if (exp_cpu_gnt) begin
      ref_last = 0;
      if (cpu_we) ref_mem[cpu_addr[7:0]] = cpu_wdata;
      else begin ref_resp = 1; ref_resp_data = ref_mem[cpu_addr[7:0]]; end
    end
    if (exp_vid_gnt) begin
      ref_last      = 1;
      ref_resp      = 2;
      ref_resp_data = ref_mem[vid_addr[7:0]];
    end
`ifdef DMEM_ARB_RR_EN
    ref_wait = 0;
`else
    if (vid_req && !exp_vid_gnt) ref_wait = (ref_wait < MAX_WAIT) ? ref_wait + 1 : MAX_WAIT;
    else                         ref_wait = 0;
`endif
  endtask

  task automatic cycle(input bit creq, input bit cwe, input logic [AW-1:0] caddr,
                       input logic [DW-1:0] cwdata, input bit vreq, input logic [AW-1:0] vaddr);
    applyStimulus(creq, cwe, caddr, cwdata, vreq, vaddr);
    #3;
    checkOutput();
    finish_cycle();
  endtask

  initial begin
    bit            cr, cw, vr;
    logic [AW-1:0] ca, va;
    logic [DW-1:0] cd;
    logic [DW-1:0] w;

    for (int i = 0; i < 256; i++) begin
      w = $urandom;
      dmem_words[i] = w;
      ref_mem[i]    = w;
    end
    dmem_words[254] = 32'h6D;
    ref_mem[254]    = 32'h6D;
    ref_reset();

    // Requests raised while in reset must not reach the memory port.
    applyStimulus(1'b1, 1'b0, 32'd5, 32'd0, 1'b1, 32'd6);
    #2;
    checkOutput();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    $display("[TB] reset released");

    cycle(1'b1, 1'b0, 32'd254, 32'd0, 1'b0, 32'd0);
    applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
    #3;
    checkOutput();
    check_val("switch_word", cpu_rdata, 32'h6D);
    finish_cycle();

    cycle(1'b1, 1'b1, 32'd8, 32'hDEADBEEF, 1'b0, 32'd0);
    cycle(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
    cycle(1'b1, 1'b0, 32'd8, 32'd0, 1'b0, 32'd0);
    cycle(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0);

    $display("[TB] contention sequence");
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 1'b0, 32'(10 + i), 32'd0, 1'b1, 32'd20);
      #3;
      checkOutput();
`ifndef DMEM_ARB_RR_EN
      check_val("fixed_cpu_gnt", 32'(cpu_gnt), 32'(i != 4));
`endif
      finish_cycle();
    end
    cycle(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0);

    $display("[TB] video back-to-back");
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 32'(i));
    cycle(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0);

    $display("[TB] random traffic");
    cr = 1'b0; cw = 1'b0; ca = '0; cd = '0; vr = 1'b0; va = '0;
    for (int i = 0; i < 400; i++) begin
      if (!(cr && !exp_cpu_gnt && $urandom_range(7) != 0)) begin
        cr = ($urandom_range(3) != 0);
        cw = ($urandom_range(3) == 0);
        ca = 32'($urandom_range(253));
        cd = $urandom;
      end
      if (!(vr && !exp_vid_gnt && $urandom_range(7) != 0)) begin
        vr = ($urandom_range(2) != 0);
        va = 32'($urandom_range(255));
      end
      cycle(cr, cw, ca, cd, vr, va);
    end
    cycle(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0);

    $display("[TB] reset during read");
    cycle(1'b1, 1'b0, 32'd30, 32'd0, 1'b1, 32'd40);
    cycle(1'b1, 1'b0, 32'd31, 32'd0, 1'b1, 32'd40);
    cycle(1'b1, 1'b0, 32'd32, 32'd0, 1'b1, 32'd40);
    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
    #1;
    ref_reset();
    checkOutput();
    check_val("rst_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
    check_val("rst_wait_cnt", 32'(wait_cnt), 32'd0);
    #1;
    rst_n = 1'b1;
    #1;
    checkOutput();
    finish_cycle();
    cycle(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
    cycle(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 32'd3);
    cycle(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
